// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
// The requester drives start/a/b and the subtractor returns busy/done/diff/borrow_out.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell and a borrow flop, LSB first.
// Each operation is WIDTH RUN cycles followed by a one-cycle done pulse.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;
    logic             busy_q;
    logic             done_q;
    logic             d_bit_c;
    logic             b_bit_c;
    logic             last_bit_c;

    // Full-subtractor cell on the current LSBs and the stored borrow.
    always_comb begin
        d_bit_c    = a_sh[0] ^ b_sh[0] ^ borrow;
        b_bit_c    = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
        last_bit_c = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit_c) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Status flags are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_next == RUN);
            done_q <= (state_next == DONE);
        end
    end

    // Operand/result shifters; diff only updates when the final bit is produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh         <= '0;
            b_sh         <= '0;
            d_sh         <= '0;
            borrow       <= 1'b0;
            cnt          <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    d_sh   <= {d_bit_c, d_sh[WIDTH-1:1]};
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    borrow <= b_bit_c;
                    cnt    <= cnt + CW'(1);
                    if (last_bit_c) begin
                        diff_q       <= {d_bit_c, d_sh[WIDTH-1:1]};
                        borrow_out_q <= b_bit_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range WIDTH >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the accepting edge.
REQ-006 b  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-007 busy  output  1  high while in RUN.
REQ-008 done  output  1  one-cycle pulse; diff/borrow_out valid.
REQ-009 diff  output  WIDTH  result (a - b) mod 2^WIDTH; held until the next accepted start.
REQ-010 borrow_out  output  1  final borrow; 1 iff a < b unsigned; held with diff.

Function
REQ-011 Datapath SHALL be one full-subtractor cell plus a borrow flip-flop, processing one bit per clock, LSB first.
REQ-012 Cell equations SHALL be D = x^y^z and B = (~x&y) | (~(x^y)&z), with x = minuend bit, y = subtrahend bit, z = borrow-in.
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at an edge SHALL load a and b into shift registers, clear the borrow FF to 0, clear the bit counter to 0, and enter RUN.
REQ-015 IDLE: start=0 SHALL leave all registers unchanged.
REQ-016 RUN, each edge: D SHALL shift into the diff register MSB with a right shift; the borrow FF SHALL take B; both operand registers SHALL shift right; the counter SHALL increment.
REQ-017 RUN SHALL last exactly WIDTH edges; the edge processing bit WIDTH-1 SHALL enter DONE and SHALL load borrow_out with that edge's B.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE on the next edge.
REQ-019 Latency: with start accepted at edge 0, done SHALL be high in the cycle following edge WIDTH and low again after edge WIDTH+1.
REQ-020 start SHALL be ignored in RUN and DONE; there are no queued requests.
REQ-021 Changes on a and b after the accepting edge SHALL NOT affect the result.
REQ-022 diff SHALL be stable during RUN at its previous value; shifting SHALL use an internal register that is copied to diff on entry to DONE.
REQ-023 busy SHALL equal (state==RUN) and done SHALL equal (state==DONE), both registered-state decodes with no combinational path from inputs.
REQ-024 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during a run.
REQ-025 Back-to-back operation: start high in the IDLE cycle immediately after DONE SHALL be accepted, giving a minimum period of WIDTH+2 cycles.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, diff=0, borrow_out=0, and all operand, borrow and counter registers to 0.
REQ-027 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow; the next start after rst deasserts SHALL operate normally.

Verification (WIDTH=8)
REQ-028 a=200, b=55, start pulse -> done 9 cycles after the accepting edge, diff=145, borrow_out=0, busy high for exactly 8 cycles.
REQ-029 a=5, b=9 -> diff=8'hFC, borrow_out=1; a=0, b=1 -> diff=8'hFF, borrow_out=1, with the borrow rippling through all 8 bits.
REQ-030 a=8'hAA, b=8'hAA -> diff=0, borrow_out=0; then a=8'hFF, b=0 back-to-back in the next IDLE cycle -> diff=8'hFF, borrow_out=0, with a 10-cycle period between start acceptances.
REQ-031 start held high throughout, with a and b randomised every cycle during RUN -> result matches the operands captured at the accepting edge; no extra run is started while in RUN or DONE.
REQ-032 rst pulsed asynchronously (between edges) during RUN at bit 4 -> all outputs go to 0 before the next edge, no done pulse; a subsequent run with a=100, b=37 gives diff=63, borrow_out=0.
REQ-033 Exhaustive check of all 8 x,y,z cell combinations (via operands a,b in {0,1} with forced borrow states) -> D/B match the truth table; a random 1000-pair sweep against the model (a-b) mod 256 and (a<b) shows no mismatch.
